// File: rtl/md_pkg.sv
// Shared types and helpers for the multiply/divide sequencer.
// State encoding, op codes and two's-complement negation.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Widest value neg2c handles; callers zero-extend and truncate.
  localparam int MAXW = 128;

  function automatic logic [MAXW-1:0] neg2c(
    input logic [MAXW-1:0] x
  );
    return ~x + MAXW'(1);
  endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// Shared adder plus {hi,lo} shift registers for shift-add multiply and restoring divide.
// Ports: clk, rst_n, load/init_*, iter, op in; hi, lo out.
module md_iter_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             iter,
  input  logic             op,
  input  logic [WIDTH-1:0] init_hi,
  input  logic [WIDTH-1:0] init_lo,
  input  logic [WIDTH-1:0] init_m,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH+1:0] sum;

  // Divide: subtract m from the left-shifted remainder; the top
  // bit of sum is the no-borrow flag. Multiply: plain add, sum[WIDTH]
  // is the carry kept for the right shift.
  assign add_a = (op == OP_DIV) ? {hi, lo[WIDTH-1]} : {1'b0, hi};
  assign add_b = (op == OP_DIV) ? ~{1'b0, m} : {1'b0, m};
  assign sum   = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
      m  <= '0;
    end else if (load) begin
      hi <= init_hi;
      lo <= init_lo;
      m  <= init_m;
    end else if (iter) begin
      if (op == OP_DIV) begin
        if (sum[WIDTH+1]) begin
          hi <= sum[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= add_a[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else if (lo[0]) begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end else begin
        hi <= {1'b0, hi[WIDTH-1:1]};
        lo <= {hi[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 32-step iterate then sign fix.
// Ports: Clk, Reset(n), Start, Op, Unsigned, A, B, Abort in; Busy, Done, DivZero, Hi, Lo out.
module mult_div_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic op_q, sa_q, sb_q, dz_q;
  logic sa, sb, div0, load, iter;
  logic [WIDTH-1:0] na, nb, mag_a, mag_b;
  logic [WIDTH-1:0] init_hi, init_lo, init_m;
  logic [WIDTH-1:0] dp_hi, dp_lo, nhi, nlo;
  logic [2*WIDTH-1:0] nprod;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign sa    = ~Unsigned & A[WIDTH-1];
  assign sb    = ~Unsigned & B[WIDTH-1];
  assign na    = WIDTH'(neg2c(MAXW'(A)));
  assign nb    = WIDTH'(neg2c(MAXW'(B)));
  assign mag_a = sa ? na : A;
  assign mag_b = sb ? nb : B;
  assign div0  = (Op == OP_DIV) && (B == '0);

  assign load = (state == IDLE) && Start;
  assign iter = (state == RUN) && !Abort;

  // Divide by zero preloads the final Hi/Lo so SIGN just copies them.
  assign init_hi = div0 ? A : '0;
  assign init_lo = div0 ? '1 : ((Op == OP_DIV) ? mag_a : mag_b);
  assign init_m  = (Op == OP_DIV) ? mag_b : mag_a;

  md_iter_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (Clk),
    .rst_n   (Reset),
    .load    (load),
    .iter    (iter),
    .op      (op_q),
    .init_hi (init_hi),
    .init_lo (init_lo),
    .init_m  (init_m),
    .hi      (dp_hi),
    .lo      (dp_lo)
  );

  assign nhi   = WIDTH'(neg2c(MAXW'(dp_hi)));
  assign nlo   = WIDTH'(neg2c(MAXW'(dp_lo)));
  assign nprod = (2*WIDTH)'(neg2c(MAXW'({dp_hi, dp_lo})));

  always_comb begin
    res_hi = dp_hi;
    res_lo = dp_lo;
    if (op_q == OP_DIV) begin
      if (sa_q ^ sb_q) res_lo = nlo;
      if (sa_q)        res_hi = nhi;
    end else if (sa_q ^ sb_q) begin
      {res_hi, res_lo} = nprod;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            op_q  <= Op;
            sa_q  <= sa & ~div0;
            sb_q  <= sb & ~div0;
            dz_q  <= div0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= div0 ? SIGN : RUN;
          end
        end
        RUN: begin
          if (Abort) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= SIGN;
          end
        end
        SIGN: begin
          Busy  <= 1'b0;
          state <= IDLE;
          if (!Abort) begin
            Hi   <= res_hi;
            Lo   <= res_lo;
            Done <= 1'b1;
            if (op_q == OP_DIV) DivZero <= dz_q;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: vector table plus abort/reset/back-to-back sequences.
// Drives on negedge, samples on negedge.
module tb_mult_div_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Op;
  logic        Unsigned;
  logic [31:0] A;
  logic [31:0] B;
  logic        Abort;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vt[13];

  mult_div_sequencer #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .Unsigned (Unsigned),
    .A        (A),
    .B        (B),
    .Abort    (Abort),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic op, input logic uns,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; Unsigned = uns; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; Op = ~op; Unsigned = ~uns; A = ~a; B = ~b;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    while (cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (Busy) busy_n++;
      if (Done) break;
    end
  endtask

  initial begin
    int cyc, bn, dn;
    Reset = 1'b0; Start = 1'b0; Op = 1'b0; Unsigned = 1'b0;
    A = '0; B = '0; Abort = 1'b0;

    vt[0]  = '{1'b0, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vt[1]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vt[2]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vt[3]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vt[4]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vt[5]  = '{1'b1, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vt[6]  = '{1'b1, 1'b0, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 2};
    vt[7]  = '{1'b1, 1'b0, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0, 34};
    vt[8]  = '{1'b1, 1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2};
    vt[9]  = '{1'b0, 1'b1, 32'd3,        32'd4,        32'd0,        32'd12,       1'b1, 34};
    vt[10] = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34};
    vt[11] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 34};
    vt[12] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, 34};

    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dz", 32'(DivZero), 32'd0);

    issue(1'b0, 1'b0, 32'd7, 32'd3);
    repeat (5) @(negedge Clk);
    chk("run_busy", 32'(Busy), 32'd1);
    Reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    chk("midrst_nodone", 32'(dn), 32'd0);
    chk("midrst_lo", Lo, 32'd0);

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].uns, vt[i].a, vt[i].b);
      wait_done(cyc, bn);
      chk($sformatf("v%0d_lat", i), 32'(cyc), 32'(vt[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(bn), 32'(vt[i].lat - 1));
      chk($sformatf("v%0d_hi", i), Hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), Lo, vt[i].lo);
      chk($sformatf("v%0d_dz", i), 32'(DivZero), 32'(vt[i].dz));
    end

    issue(1'b0, 1'b0, 32'd3, 32'd5);
    repeat (9) @(negedge Clk);
    Abort = 1'b1;
    @(posedge Clk);
    #1 Abort = 1'b0;
    @(negedge Clk);
    chk("abort_busy", 32'(Busy), 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    chk("abort_nodone", 32'(dn), 32'd0);
    chk("abort_hi", Hi, 32'hF);
    chk("abort_lo", Lo, 32'h0FFFFFFF);

    issue(1'b1, 1'b0, 32'h55, 32'd0);
    Abort = 1'b1;
    @(posedge Clk);
    #1 Abort = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Done) dn++;
    end
    chk("absign_nodone", 32'(dn), 32'd0);
    chk("absign_busy", 32'(Busy), 32'd0);
    chk("absign_dz", 32'(DivZero), 32'd0);
    chk("absign_hi", Hi, 32'hF);
    chk("absign_lo", Lo, 32'h0FFFFFFF);

    issue(1'b0, 1'b1, 32'd2, 32'd3);
    repeat (5) @(negedge Clk);
    Start = 1'b1; Op = 1'b1; Unsigned = 1'b0; A = 32'h99; B = 32'd0;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done(cyc, bn);
    chk("ign_lat", 32'(cyc + 5), 32'd34);
    chk("ign_hi", Hi, 32'd0);
    chk("ign_lo", Lo, 32'd6);
    chk("ign_dz", 32'(DivZero), 32'd0);

    Start = 1'b1; Op = 1'b1; Unsigned = 1'b1; A = 32'd100; B = 32'd7;
    Abort = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0; Abort = 1'b0; A = 32'd0; B = 32'd0;
    wait_done(cyc, bn);
    chk("b2b_lat", 32'(cyc), 32'd34);
    chk("b2b_hi", Hi, 32'd2);
    chk("b2b_lo", Lo, 32'd14);
    @(negedge Clk);
    chk("b2b_pulse", 32'(Done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the HI/LO result registers and runs a 32-iteration shift-add multiply or restoring divide on one shared adder/shifter datapath. The main controlador issues a one-cycle Start and waits in a stall state until Done. MFHI/MFLO read Hi/Lo directly, and the exception path can cancel an operation in flight with Abort.

Parameters:
WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low; low clears all state immediately.
Start  in  1  one-cycle request; sampled only in IDLE.
Op  in  1  0 = multiply, 1 = divide.
Unsigned  in  1  1 = MULTU/DIVU, 0 = signed.
A  in  WIDTH  rs operand (multiplicand or dividend).
B  in  WIDTH  rt operand (multiplier or divisor).
Abort  in  1  cancel the operation in flight; Hi/Lo are not updated.
Busy  out  1  high while an operation is in progress.
Done  out  1  one-cycle pulse; Hi/Lo hold the new result in the same cycle.
DivZero  out  1  sticky flag: last completed divide had B == 0.
Hi  out  WIDTH  HI register.
Lo  out  WIDTH  LO register.

Behaviour:
- Reset (Reset low, asynchronous): state = IDLE; Busy, Done and DivZero = 0; Hi and Lo = 0; iteration counter = 0. Reset low in the middle of an operation discards it.
- States: IDLE, RUN, SIGN.
- IDLE, Start = 1 at edge T0:
  - Latch sign flags. Signs are forced to 0 when Unsigned = 1.
  - Latch |A| and |B| as WIDTH-bit magnitudes; |0x80000000| = 0x80000000 treated as unsigned.
  - Latch Op; counter = 0.
  - Normal case: go to RUN, Busy = 1.
  - Op = 1 and B == 0: go straight to SIGN with the div-zero result preloaded.
- RUN: one iteration per edge; counter increments each edge. The edge where counter == WIDTH-1 moves to SIGN. Iterations occur at edges T1..T32.
  - Multiply: 2·WIDTH-bit product register {P_hi, P_lo}, initialised to {0, |B|}. Each edge: if P_lo[0] = 1, add |A| to P_hi, keeping the carry bit; then shift right by 1.
  - Divide (restoring): remainder R initialised to 0, quotient Q initialised to |A|. Each edge: {R, Q} <<= 1; trial = R - |B|. If trial ≥ 0, R = trial and Q[0] = 1.
- SIGN, one edge (T33 normally, T1 for div-by-zero): write Hi/Lo, Done = 1 for one cycle, Busy = 0, return to IDLE.
  - Multiply: {Hi, Lo} = product, two's-complement negated over 2·WIDTH bits if sign(A) XOR sign(B).
  - Divide: Lo = Q, negated if sign(A) XOR sign(B). Hi = R, negated if sign(A), so the remainder takes the dividend's sign.
  - Divide overflow: 0x80000000 / 0xFFFFFFFF (signed) gives Lo = 0x80000000, Hi = 0, no flag.
  - Divide by zero: Hi = A unchanged, Lo = 0xFFFFFFFF, DivZero = 1.
  - Any completed divide with B != 0 clears DivZero. Multiplies leave DivZero unchanged.
- Latency from the edge sampling Start to Done high:
  - 34 cycles for any multiply or divide with B != 0 (Done is visible in the cycle after edge T33).
  - 2 cycles for divide-by-zero.
- Start while Busy = 1: ignored, no queueing. Start in the Done cycle (state is IDLE) is accepted, so back-to-back operations work.
- Abort = 1 in RUN or SIGN: next edge goes to IDLE, Busy = 0, no Done, Hi/Lo/DivZero unchanged.
  - Abort takes priority over the SIGN-state write.
  - Abort in IDLE has no effect. If Abort and Start are both high in IDLE, Start wins.
- Hi/Lo change only in SIGN or on reset. A, B, Op and Unsigned may change freely after the Start edge.

Decomposition:
- Package md_pkg:
  - state enum {IDLE, RUN, SIGN};
  - localparams OP_MULT = 1'b0, OP_DIV = 1'b1;
  - function neg2c for WIDTH and 2·WIDTH negation.
- One natural sub-module: md_iter_datapath, the shared adder/subtractor plus shift registers. It is controlled by the Op latch and an iterate enable from the FSM.
- FSM, counter, sign latches and Hi/Lo stay in the top module.

Test Plan:
1. Reset low for 3 cycles, then high → Hi = Lo = 0, Busy = Done = DivZero = 0. Assert Reset low during RUN → Busy drops immediately, no Done follows.
2. Signed MULT A = 7, B = 0xFFFFFFFD (-3) → Done in the 34th cycle after the Start edge with Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. Busy is high for exactly 33 cycles.
3. Signed MULT 0x80000000 × 0x80000000 → Hi = 0x40000000, Lo = 0. MULTU 0xFFFFFFFF × 0xFFFFFFFF → Hi = 0xFFFFFFFE, Lo = 0x00000001.
4. Signed DIV A = 0xFFFFFFF9 (-7), B = 2 → Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. Signed DIV 0x80000000 / 0xFFFFFFFF → Lo = 0x80000000, Hi = 0. DIVU 100 / 7 → Lo = 14, Hi = 2.
5. DIV with B = 0, A = 0x12345678 → Done 2 cycles after Start with Hi = 0x12345678, Lo = 0xFFFFFFFF, DivZero = 1. The next DIV 9 / 3 → DivZero = 0, Lo = 3, Hi = 0.
6. Start a MULT, pulse Abort at RUN iteration 10 → Busy = 0 next cycle, no Done, Hi/Lo keep their prior values. Start pulsed again mid-RUN → ignored. Start in the Done cycle → new operation accepted.
